// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO responder.
// FSM states, register offsets and STATUS bit positions.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MMIO_RESP,
    MEM_WAIT,
    MEM_RESP
  } state_t;

  localparam logic [11:0] OFF_COUNTER = 12'd0;
  localparam logic [11:0] OFF_SCRATCH = 12'd1;
  localparam logic [11:0] OFF_LED     = 12'd2;
  localparam logic [11:0] OFF_TXDATA  = 12'd4;
  localparam logic [11:0] OFF_STATUS  = 12'd5;

  localparam int ST_FULL  = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_OVF   = 10;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte-wide TX queue for the MMIO responder.
// Pointers wrap modulo DEPTH; count is one bit wider than the pointers.
module mmio_tx_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees a slot, so a push into a full queue still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Data-side responder: DMEM syncram passthrough plus MMIO registers.
// Define MMIO_CYCLE_COUNTER_EN to build the free-running cycle counter.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wren,
  input  logic [11:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] q,
  output logic        ack,
  output logic        busy,
  output logic [11:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic [31:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  state_t          state_nx;
  logic            accept;
  logic            is_mmio;
  logic [11:0]     offset;
  logic [31:0]     rdata;
  logic [31:0]     scratch;
  logic [31:0]     cycles;
  logic            ovf;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            stat_rd;

  assign is_mmio = (address >= MMIO_BASE);
  assign offset  = address - MMIO_BASE;
  assign accept  = (state == IDLE) & req & ~reset;
  assign busy    = (state != IDLE);

  assign mem_address = address;
  assign mem_data    = wdata;
  assign mem_wren    = accept & ~is_mmio & wren;

  assign push    = accept & is_mmio & wren & (offset == OFF_TXDATA);
  assign stat_rd = accept & is_mmio & ~wren & (offset == OFF_STATUS);
  assign pop     = tx_valid & tx_ready;
  assign tx_valid = ~empty;

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .data  (wdata[7:0]),
    .pop   (pop),
    .head  (tx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end
`else
  assign cycles = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_mmio)   state_nx = MMIO_RESP;
          else if (wren) state_nx = MEM_RESP;
          else           state_nx = MEM_WAIT;
        end
      end
      MEM_WAIT: state_nx = MEM_RESP;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_COUNTER: rdata = cycles;
      OFF_SCRATCH: rdata = scratch;
      OFF_LED:     rdata = led;
      OFF_STATUS: begin
        rdata[7:0]      = 8'(count);
        rdata[ST_FULL]  = full;
        rdata[ST_EMPTY] = empty;
        rdata[ST_OVF]   = ovf;
      end
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack     <= 1'b0;
      q       <= '0;
      led     <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (accept && is_mmio) begin
        ack <= 1'b1;
        q   <= wren ? 32'd0 : rdata;
        if (wren && offset == OFF_SCRATCH) scratch <= wdata;
        if (wren && offset == OFF_LED)     led     <= wdata;
      end else if (accept && wren) begin
        ack <= 1'b1;
        q   <= '0;
      end
      if (state == MEM_WAIT) begin
        ack <= 1'b1;
        q   <= mem_q;
      end
      // Reading STATUS reports the overflow and then clears it.
      if (stat_rd)                 ovf <= 1'b0;
      else if (push && full && !pop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder with a DMEM syncram model
// and a queue-based reference of the MMIO register file.
module tb_mmio_responder;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        wren;
  logic [11:0] address;
  logic [31:0] wdata;
  logic [31:0] q;
  logic        ack;
  logic        busy;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [31:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int pass_cnt = 0;
  int check_cnt = 0;
  int wren_cnt = 0;

  logic [31:0] dmem [4096];
  logic [31:0] shadow [int];
  logic [7:0]  tx_m [$];
  bit          ovf_m;
  logic [31:0] led_m;
  logic [31:0] scratch_m;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) dmem[mem_address] <= mem_data;
    mem_q <= dmem[mem_address];
  end

  always @(negedge clock) begin
    if (mem_wren) wren_cnt++;
  end

  mmio_responder #(
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (12'hF00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .wren        (wren),
    .address     (address),
    .wdata       (wdata),
    .q           (q),
    .ack         (ack),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .led         (led),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[7:0] = 8'(tx_m.size());
    s[8]   = (tx_m.size() == DEPTH);
    s[9]   = (tx_m.size() == 0);
    s[10]  = ovf_m;
    return s;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (tx_m.size() < DEPTH) tx_m.push_back(b);
    else ovf_m = 1'b1;
  endfunction

  // Issues one request from IDLE; returns q and ack latency (0 = no ack).
  task automatic issue(input logic w, input logic [11:0] a,
                       input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
    req = 1'b1; wren = w; address = a; wdata = d;
    @(posedge clock); #1;
    req = 1'b0;
    lat = 0;
    rd = '0;
    for (int i = 1; i <= 6; i++) begin
      if (ack) begin
        lat = i;
        rd = q;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; wren = 1'b0;
    address = '0; wdata = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_cnt++;
    if ({ack, busy, mem_wren, tx_valid} !== 4'b0)
      $display("FAIL reset_ctrl got=%b want=0000",
               {ack, busy, mem_wren, tx_valid});
    else pass_cnt++;
    check_cnt++;
    if (q !== 32'd0 || led !== 32'd0)
      $display("FAIL reset_data q=%h led=%h want 0", q, led);
    else pass_cnt++;
    reset = 1'b0;
    tx_m.delete(); ovf_m = 0; led_m = '0; scratch_m = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_dmem();
    logic [31:0] rd;
    logic [11:0] a;
    logic [31:0] d;
    int lat;
    int w0;
    for (int n = 0; n < 6; n++) begin
      a = (n == 0) ? 12'h010 : 12'($urandom_range(0, 12'hEFF));
      d = (n == 0) ? 32'h000001A5 : $urandom;
      w0 = wren_cnt;
      issue(1'b1, a, d, rd, lat);
      shadow[int'(a)] = d;
      check_cnt++;
      if (lat !== 1 || rd !== 32'd0 || wren_cnt - w0 !== 1)
        $display("FAIL dmem_wr a=%h lat=%0d q=%h wrens=%0d want 1/0/1",
                 a, lat, rd, wren_cnt - w0);
      else pass_cnt++;
      w0 = wren_cnt;
      issue(1'b0, a, 32'd0, rd, lat);
      check_cnt++;
      if (lat !== 2 || rd !== shadow[int'(a)] || wren_cnt != w0)
        $display("FAIL dmem_rd a=%h lat=%0d q=%h want lat=2 q=%h",
                 a, lat, rd, shadow[int'(a)]);
      else pass_cnt++;
      check_cnt++;
      if (ack !== 1'b0 || busy !== 1'b0)
        $display("FAIL dmem_idle ack=%b busy=%b want 0 0", ack, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    logic [31:0] d;
    logic [11:0] un [3];
    int lat;
    issue(1'b1, 12'hF02, 32'hDEADBEEF, rd, lat);
    led_m = 32'hDEADBEEF;
    check_cnt++;
    if (lat !== 1 || led !== led_m)
      $display("FAIL led_wr lat=%0d led=%h want 1 %h", lat, led, led_m);
    else pass_cnt++;
    issue(1'b0, 12'hF02, 32'd0, rd, lat);
    check_cnt++;
    if (lat !== 1 || rd !== led_m)
      $display("FAIL led_rd lat=%0d q=%h want 1 %h", lat, rd, led_m);
    else pass_cnt++;
    for (int n = 0; n < 3; n++) begin
      d = $urandom;
      issue(1'b1, 12'hF01, d, rd, lat);
      scratch_m = d;
      issue(1'b0, 12'hF01, 32'd0, rd, lat);
      check_cnt++;
      if (lat !== 1 || rd !== scratch_m)
        $display("FAIL scratch lat=%0d q=%h want 1 %h", lat, rd, scratch_m);
      else pass_cnt++;
    end
    issue(1'b1, 12'hF05, $urandom, rd, lat);
    issue(1'b1, 12'hF00, $urandom, rd, lat);
    issue(1'b0, 12'hF05, 32'd0, rd, lat);
    check_cnt++;
    if (rd !== exp_status() || led !== led_m)
      $display("FAIL ro_write status=%h led=%h want %h %h",
               rd, led, exp_status(), led_m);
    else pass_cnt++;
    un[0] = 12'hF03; un[1] = 12'hF04; un[2] = 12'hFFF;
    foreach (un[k]) begin
      issue(1'b0, un[k], 32'd0, rd, lat);
      check_cnt++;
      if (lat !== 1 || rd !== 32'd0)
        $display("FAIL unmapped a=%h lat=%0d q=%h want 1 0", un[k], lat, rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [7:0] b;
    int lat;
    tx_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      b = 8'($urandom);
      issue(1'b1, 12'hF04, {24'($urandom), b}, rd, lat);
      model_push(b);
    end
    issue(1'b0, 12'hF05, 32'd0, rd, lat);
    check_cnt++;
    if (rd !== exp_status() || rd[10:0] !== 11'h508)
      $display("FAIL status_ovf got=%h want %h", rd, exp_status());
    else pass_cnt++;
    ovf_m = 0;
    issue(1'b0, 12'hF05, 32'd0, rd, lat);
    check_cnt++;
    if (rd !== exp_status() || rd[10] !== 1'b0)
      $display("FAIL status_clr got=%h want %h", rd, exp_status());
    else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    logic [31:0] rd;
    logic [7:0] b;
    int lat;
    b = 8'($urandom);
    req = 1'b1; wren = 1'b1; address = 12'hF04; wdata = {24'd0, b};
    tx_ready = 1'b1;
    @(posedge clock); #1;
    req = 1'b0; tx_ready = 1'b0;
    void'(tx_m.pop_front());
    model_push(b);
    check_cnt++;
    if (ack !== 1'b1)
      $display("FAIL pp_ack got=%b want 1", ack);
    else pass_cnt++;
    @(posedge clock); #1;
    issue(1'b0, 12'hF05, 32'd0, rd, lat);
    check_cnt++;
    if (rd !== exp_status())
      $display("FAIL pp_full status=%h want %h", rd, exp_status());
    else pass_cnt++;
  endtask

  task automatic test_drain();
    logic [31:0] rd;
    logic [7:0] e;
    int lat;
    int bad;
    bad = 0;
    tx_ready = 1'b1;
    for (int n = 0; n < 20 && tx_m.size() > 0; n++) begin
      e = tx_m.pop_front();
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        bad++;
        $display("FAIL drain_%0d data=%h valid=%b want %h 1",
                 n, tx_data, tx_valid, e);
      end
      @(posedge clock); #1;
    end
    tx_ready = 1'b0;
    check_cnt++;
    if (bad != 0 || tx_valid !== 1'b0)
      $display("FAIL drain errors=%0d valid=%b want 0 0", bad, tx_valid);
    else pass_cnt++;
    issue(1'b0, 12'hF05, 32'd0, rd, lat);
    check_cnt++;
    if (rd !== exp_status())
      $display("FAIL drain_status got=%h want %h", rd, exp_status());
    else pass_cnt++;
  endtask

  task automatic test_order();
    logic [31:0] rd;
    int lat;
    tx_ready = 1'b0;
    issue(1'b1, 12'hF04, 32'h41, rd, lat);
    issue(1'b1, 12'hF04, 32'h42, rd, lat);
    tx_ready = 1'b1;
    check_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41)
      $display("FAIL order_0 data=%h valid=%b want 41 1", tx_data, tx_valid);
    else pass_cnt++;
    @(posedge clock); #1;
    check_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h42)
      $display("FAIL order_1 data=%h valid=%b want 42 1", tx_data, tx_valid);
    else pass_cnt++;
    @(posedge clock); #1;
    tx_ready = 1'b0;
    check_cnt++;
    if (tx_valid !== 1'b0)
      $display("FAIL order_end valid=%b want 0", tx_valid);
    else pass_cnt++;
    issue(1'b0, 12'hF05, 32'd0, rd, lat);
    check_cnt++;
    if (rd[9] !== 1'b1 || rd[7:0] !== 8'd0)
      $display("FAIL order_empty status=%h want empty=1 count=0", rd);
    else pass_cnt++;
  endtask

  task automatic test_counter();
    logic [31:0] r1;
    logic [31:0] r2;
    int lat;
    int k;
    k = $urandom_range(0, 20);
    issue(1'b0, 12'hF00, 32'd0, r1, lat);
    repeat (k) @(posedge clock);
    #0;
    issue(1'b0, 12'hF00, 32'd0, r2, lat);
    check_cnt++;
`ifdef MMIO_CYCLE_COUNTER_EN
    if (r2 - r1 !== 32'(k + 2))
      $display("FAIL counter diff=%0d want %0d", r2 - r1, k + 2);
    else pass_cnt++;
`else
    if (r1 !== 32'd0 || r2 !== 32'd0)
      $display("FAIL counter r1=%h r2=%h want 0 0", r1, r2);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int lat;
    int acks;
    req = 1'b1; wren = 1'b0; address = 12'h010;
    @(posedge clock); #1;
    req = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tx_m.delete(); ovf_m = 0; led_m = '0; scratch_m = '0;
    check_cnt++;
    if (busy !== 1'b0 || ack !== 1'b0)
      $display("FAIL abort_idle busy=%b ack=%b want 0 0", busy, ack);
    else pass_cnt++;
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      if (ack) acks++;
      @(posedge clock); #1;
    end
    check_cnt++;
    if (acks != 0 || led !== 32'd0)
      $display("FAIL abort_noack acks=%0d led=%h want 0 0", acks, led);
    else pass_cnt++;
    issue(1'b0, 12'h010, 32'd0, rd, lat);
    check_cnt++;
    if (lat !== 2 || rd !== shadow[32'h010])
      $display("FAIL abort_next lat=%0d q=%h want 2 %h",
               lat, rd, shadow[32'h010]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_dmem();
    test_regs();
    test_overflow();
    test_push_pop_full();
    test_drain();
    test_order();
    test_counter();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter MMIO_BASE, default 12'hF00, first MMIO address; all lower addresses are DMEM.
REQ-003 SHALL have port clock  in  1  single clock for all state.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req  in  1  processor data-side request strobe, one cycle.
REQ-006 SHALL have port wren  in  1  request is a write when 1, a read when 0.
REQ-007 SHALL have port address  in  12  word address.
REQ-008 SHALL have port wdata  in  32  write data.
REQ-009 SHALL have port q  out  32  read data, valid only while ack=1.
REQ-010 SHALL have port ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  out  1  request in flight; req ignored while 1.
REQ-012 SHALL have ports mem_address out 12, mem_data out 32, mem_wren out 1 and mem_q in 32, driving the 1-cycle-latency DMEM syncram.
REQ-013 SHALL have ports led out 32, tx_data out 8, tx_valid out 1 and tx_ready in 1.

Function
REQ-014 SHALL implement FSM IDLE -> {MMIO_RESP, MEM_WAIT -> MEM_RESP} -> IDLE; req is sampled only in IDLE.
REQ-015 SHALL, for DMEM write (address<MMIO_BASE, wren=1), assert mem_wren for exactly the accept cycle and pulse ack the next cycle; q=0.
REQ-016 SHALL, for DMEM read, present mem_address in the accept cycle, wait in MEM_WAIT one cycle, and register mem_q into q with ack on cycle +2.
REQ-017 SHALL, for MMIO access, pulse ack on cycle +1 with q per the register map; writes to read-only offsets are discarded with no side effect.
REQ-018 SHALL map offset 0 to the cycle counter (RO, 32-bit wrapping), 1 to SCRATCH (RW), 2 to LED (RW, drives led), 4 to TXDATA (WO, push wdata[7:0]), 5 to STATUS (RO: [7:0] fifo count, [8] full, [9] empty, [10] sticky overflow); unmapped offsets read 0.
REQ-019 SHALL drop a TXDATA push when the FIFO is full and set sticky overflow; overflow clears on a STATUS read.
REQ-020 SHALL drive tx_valid whenever the FIFO is non-empty, with tx_data at head; pop on tx_valid&tx_ready.
REQ-021 SHALL, on simultaneous push and pop while full, accept both so the count is unchanged; on simultaneous push and pop while empty, perform the push only.
REQ-022 SHALL wrap FIFO pointers modulo FIFO_DEPTH and keep the count width at clog2(FIFO_DEPTH)+1.
REQ-023 SHALL drive busy=1 in every non-IDLE state; ack SHALL never be asserted on two consecutive cycles.

Reset
REQ-024 SHALL, on reset, force FSM to IDLE; ack, busy, mem_wren, tx_valid, q, led, SCRATCH, counter, FIFO pointers, count and overflow all to 0.
REQ-025 SHALL let reset abort an in-flight request with no ack and no write side effect after the reset cycle.

Configuration
REQ-026 SHALL honour macro MMIO_CYCLE_COUNTER_EN: defined -> offset 0 is a free-running counter incremented every non-reset cycle; undefined -> no counter flops, offset 0 reads 0.

Structure
REQ-027 SHALL put the FSM state enum, MMIO offset constants and STATUS bit positions in shared package mmio_pkg.
REQ-028 SHALL implement the TX queue as sub-module mmio_tx_fifo (push, pop, full, empty, count).

Verification
REQ-029 SHALL check: write 0x000001A5 to 0x010, then read 0x010 -> read ack is 2 cycles after req with q=0x000001A5, and mem_wren is high for exactly 1 cycle.
REQ-030 SHALL check: write 0xDEADBEEF to 0xF02 -> led=0xDEADBEEF one cycle after req; reading 0xF02 returns the same value with ack on cycle +1.
REQ-031 SHALL check: 9 TXDATA pushes with tx_ready=0 (FIFO_DEPTH=8) -> STATUS reads count=8, full=1, overflow=1; a second STATUS read shows overflow=0.
REQ-032 SHALL check: push 0x41,0x42 then tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive cycles, after which tx_valid=0 and empty=1.
REQ-033 SHALL check: with MMIO_CYCLE_COUNTER_EN defined, two reads of 0xF00 issued N cycles apart differ by N; with it undefined, both return 0.
REQ-034 SHALL check: reset asserted in MEM_WAIT -> no ack; busy=0 the cycle after reset; the next req completes normally.
